// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and fault check for the loadable instruction memory
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } imem_state_e;

   // addi x0,x0,0
   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

   // A fetch faults when it is not word aligned or its word index lies past the array.
   function automatic logic fetch_is_fault(input logic [1:0]  byte_off,
                                           input logic [63:0] word_idx,
                                           input logic [63:0] depth);
      return (byte_off != 2'b00) || (word_idx >= depth);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - simple dual-port word RAM, one write port and one registered read port
module imem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int LAW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LAW-1:0]    waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [LAW-1:0]    raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on the array or the read register so the tools can map this onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - instruction memory with registered fetch port and runtime program load
module instr_mem_loadable
   import imem_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 1024,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP),
   parameter int                LAW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A,
   input  logic              fetch_req,
   input  logic              fetch_stall,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] RD,
   output logic              rd_valid,
   output logic              fetch_fault,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [LAW-1:0]    ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [LAW:0]      ld_count,
   output logic              ld_err,
   output logic              prog_loaded
);

   localparam logic [LAW:0] DEPTH_CNT = (LAW+1)'(DEPTH);

   imem_state_e       state;
   logic              full;
   logic              mem_we;
   logic              fetch_acc;
   logic              fault_now;
   logic              ram_re;
   logic              sel_ram;
   logic [DATA_W-1:0] ram_q;

   assign ld_ready    = (state == IDLE) || (state == LOAD);
   assign fetch_ready = (state == RUN);
   assign prog_loaded = (state == RUN);

   assign full      = (ld_count == DEPTH_CNT);
   assign mem_we    = ld_valid & ld_ready & ~full;
   assign fetch_acc = fetch_req & fetch_ready & ~fetch_stall;
   assign fault_now = fetch_is_fault(A[1:0], 64'(A[ADDR_W-1:2]), 64'(DEPTH));
   assign ram_re    = fetch_acc & ~fault_now;

   // The RAM read register holds its word while no read is issued, so RD only needs a source select.
   assign RD = sel_ram ? ram_q : NOP_WORD;

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .LAW    (LAW)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .re    (ram_re),
      .raddr (A[LAW+1:2]),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ld_count <= '0;
         ld_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ld_valid) begin
                  ld_count <= (LAW+1)'(1);
                  state    <= ld_last ? RUN : LOAD;
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  if (!full) begin
                     ld_count <= ld_count + 1'b1;
                  end
                  if (ld_last) begin
                     state <= RUN;
                  end else if (full) begin
                     ld_err <= 1'b1;
                  end
               end
            end
            RUN: begin
               // Reload request: the word offered now is not taken, it is accepted from LOAD.
               if (ld_valid) begin
                  state    <= LOAD;
                  ld_count <= '0;
                  ld_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid    <= 1'b0;
         fetch_fault <= 1'b0;
         sel_ram     <= 1'b0;
      end else if (!fetch_stall) begin
         rd_valid <= fetch_acc;
         if (fetch_acc) begin
            fetch_fault <= fault_now;
            sel_ram     <= ~fault_now;
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - self-checking bench for instr_mem_loadable against a behavioural model
module tb_instr_mem_loadable;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A;
   logic        fetch_req, fetch_stall;
   logic        fetch_ready;
   logic [31:0] RD;
   logic        rd_valid, fetch_fault;
   logic        ld_valid, ld_ready;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   logic        ld_last;
   logic [10:0] ld_count;
   logic        ld_err, prog_loaded;

   int checks   = 0;
   int failures = 0;
   string cur = "init";

   // behavioural model: program array, load phase (0 idle, 1 loading, 2 running) and fetch outputs
   logic [31:0] mm [1024];
   bit          mk [1024];
   int          ph;
   int          mcount;
   bit          merr;
   logic [31:0] mrd;
   bit          mrd_known;
   bit          mvalid;
   bit          mfault;

   instr_mem_loadable dut (
      .clk         (clk),
      .rst         (rst),
      .A           (A),
      .fetch_req   (fetch_req),
      .fetch_stall (fetch_stall),
      .fetch_ready (fetch_ready),
      .RD          (RD),
      .rd_valid    (rd_valid),
      .fetch_fault (fetch_fault),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_count    (ld_count),
      .ld_err      (ld_err),
      .prog_loaded (prog_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s/%s observed=%h expected=%h", cur, tag, obs, exp);
      end
   endtask

   task automatic check_all();
      if (mrd_known) chk("RD", RD, mrd);
      chk("rd_valid", 32'(rd_valid), 32'(mvalid));
      chk("fetch_fault", 32'(fetch_fault), 32'(mfault));
      chk("ld_count", 32'(ld_count), 32'(mcount));
      chk("ld_err", 32'(ld_err), 32'(merr));
      chk("prog_loaded", 32'(prog_loaded), 32'(ph == 2));
      chk("fetch_ready", 32'(fetch_ready), 32'(ph == 2));
      chk("ld_ready", 32'(ld_ready), 32'(ph != 2));
   endtask

   task automatic mwrite();
      mm[ld_addr] = ld_data;
      mk[ld_addr] = 1'b1;
   endtask

   task automatic model_edge();
      bit          acc;
      bit          was_full;
      int unsigned wi;
      acc = fetch_req && (ph == 2) && !fetch_stall;
      if (!fetch_stall) begin
         mvalid = acc;
         if (acc) begin
            wi     = A / 4;
            mfault = (A % 4 != 0) || (wi >= 1024);
            if (mfault) begin
               mrd       = NOP;
               mrd_known = 1'b1;
            end else begin
               mrd       = mm[wi];
               mrd_known = mk[wi];
            end
         end
      end
      if (ld_valid) begin
         case (ph)
            0: begin
               mwrite();
               mcount = 1;
               ph     = ld_last ? 2 : 1;
            end
            1: begin
               was_full = (mcount == 1024);
               if (!was_full) begin
                  mwrite();
                  mcount++;
               end
               if (ld_last) ph = 2;
               else if (was_full) merr = 1'b1;
            end
            default: begin
               ph     = 1;
               mcount = 0;
               merr   = 1'b0;
            end
         endcase
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      fetch_req   = 1'b0;
      fetch_stall = 1'b0;
      ld_valid    = 1'b0;
      ld_last     = 1'b0;
      ld_addr     = '0;
      ld_data     = '0;
      A           = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      #1;
      ph        = 0;
      mcount    = 0;
      merr      = 1'b0;
      mrd       = NOP;
      mrd_known = 1'b1;
      mvalid    = 1'b0;
      mfault    = 1'b0;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b1;
      check_all();
   endtask

   task automatic load_word(input int addr, input logic [31:0] data, input bit last);
      ld_valid = 1'b1;
      ld_addr  = 10'(addr);
      ld_data  = data;
      ld_last  = last;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] addr);
      fetch_req = 1'b1;
      A         = addr;
      step();
      fetch_req = 1'b0;
   endtask

   initial begin
      int r;
      for (int i = 0; i < 1024; i++) mk[i] = 1'b0;
      rst = 1'b1;
      idle_inputs();
      #2;
      cur = "reset";
      do_reset();
      chk("reset_RD", RD, NOP);

      cur = "blocked";
      fetch_req = 1'b1;
      A         = 32'h0;
      for (int i = 0; i < 3; i++) step();
      chk("blocked_RD", RD, NOP);
      fetch_req = 1'b0;

      cur = "load16";
      for (int i = 0; i < 16; i++) load_word(i, 32'h001000ab + 32'(i), i == 15);
      chk("count16", 32'(ld_count), 32'd16);
      chk("loaded", 32'(prog_loaded), 32'd1);

      cur = "fetch3c";
      fetch(32'h3c);
      chk("word15", RD, 32'h001000ba);

      cur = "faults";
      fetch(32'h2);
      chk("misalign", 32'(fetch_fault), 32'd1);
      fetch(32'h1000);
      chk("range", 32'(fetch_fault), 32'd1);
      chk("range_RD", RD, NOP);

      cur = "stall";
      fetch(32'h4);
      fetch_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A         = 32'($urandom_range(0, 63)) * 4;
         fetch_req = 1'($urandom_range(0, 1));
         step();
         chk("held_word1", RD, 32'h001000ac);
      end
      fetch_stall = 1'b0;
      fetch_req   = 1'b0;

      cur = "reload";
      fetch_req = 1'b1;
      A         = 32'h8;
      ld_valid  = 1'b1;
      ld_addr   = 10'd0;
      ld_data   = 32'h00119133;
      ld_last   = 1'b1;
      step();
      chk("old_word2", RD, 32'h001000ad);
      fetch_req = 1'b0;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      fetch(32'h0);
      chk("new_word0", RD, 32'h00119133);

      cur = "random";
      for (int n = 0; n < 400; n++) begin
         ld_valid    = ($urandom_range(0, 3) == 0);
         ld_addr     = 10'($urandom_range(0, 1023));
         ld_data     = $urandom;
         ld_last     = ($urandom_range(0, 7) == 0);
         fetch_req   = 1'($urandom_range(0, 1));
         fetch_stall = ($urandom_range(0, 4) == 0);
         r = $urandom_range(0, 9);
         if (r < 6)      A = 32'($urandom_range(0, 15)) * 4;
         else if (r < 9) A = 32'($urandom_range(0, 1100)) * 4;
         else            A = $urandom;
         step();
      end
      idle_inputs();

      cur = "midload_reset";
      do_reset();
      for (int i = 0; i < 8; i++) load_word(i, $urandom, 1'b0);
      do_reset();
      chk("mid_loaded", 32'(prog_loaded), 32'd0);
      chk("mid_count", 32'(ld_count), 32'd0);
      fetch(32'h0);
      fetch(32'h4);
      chk("mid_blocked", 32'(rd_valid), 32'd0);

      cur = "overflow";
      for (int i = 0; i < 1024; i++) load_word(i, 32'h00a00000 + 32'(i), 1'b0);
      chk("ovf_count", 32'(ld_count), 32'd1024);
      chk("ovf_noerr", 32'(ld_err), 32'd0);
      load_word(5, 32'hdeadbeef, 1'b0);
      chk("ovf_err", 32'(ld_err), 32'd1);
      load_word(9, 32'h00a00009, 1'b1);
      fetch(32'h14);
      chk("ovf_dropped", RD, 32'h00a00005);
      chk("ovf_sticky", 32'(ld_err), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
